mult_issue_ctrl: RTL and testbench

Sequencing controller between the execute stage and the Booth multiplier (`multModBooths`).
- Accepts a multiply request and latches the operands.
- Issues the one-cycle start pulse to the multiplier, then stalls the pipeline until the product is ready.
- Returns the product as a single-cycle writeback. On overflow it redirects the write to the status register with the multiply exception code.
- A watchdog bounds every operation.

---
 rtl/mult_ctrl_pkg.sv | 19 +
 rtl/mult_issue_ctrl_if.sv | 36 +++
 rtl/mult_wait_counter.sv | 40 ++++
 rtl/mult_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_mult_issue_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_ctrl_pkg.sv
// rtl/mult_ctrl_pkg.sv - shared types and constants for the multiply issue controller
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int RSTATUS_REG_DEFAULT   = 30;
    localparam int MULT_OVF_CODE_DEFAULT = 4;

    // result_ready may still show the previous operation's 1 for this many WAIT cycles
    localparam int READY_GUARD = 2;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// rtl/mult_issue_ctrl_if.sv - execute-stage, multiplier and writeback signals of the issue controller
interface mult_issue_ctrl_if;

    logic        req_valid;
    logic [4:0]  req_rd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        stall;

    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] mult_result;
    logic        mult_ready;
    logic        mult_ovf;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    modport slave (
        input  req_valid, req_rd, req_a, req_b,
        input  mult_result, mult_ready, mult_ovf,
        output stall, mult_start, mult_a, mult_b,
        output wb_valid, wb_rd, wb_data, timeout_err
    );

    modport master (
        output req_valid, req_rd, req_a, req_b,
        output mult_result, mult_ready, mult_ovf,
        input  stall, mult_start, mult_a, mult_b,
        input  wb_valid, wb_rd, wb_data, timeout_err
    );

endinterface

// File: rtl/mult_wait_counter.sv
// rtl/mult_wait_counter.sv - WAIT-cycle counter providing the ready guard and the watchdog expiry
module mult_wait_counter
    import mult_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic guard_ok,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    // clear wins over increment; the FSM leaves WAIT on expiry so the count never wraps
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WAIT_CNT_W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign guard_ok = (count_q >= WAIT_CNT_W'(READY_GUARD));
    assign expired  = (count_q == WAIT_CNT_W'(TIMEOUT));

endmodule

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - sequences one multiply through the Booth multiplier and writes it back
module mult_issue_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int TIMEOUT       = 24,
    parameter int RSTATUS_REG   = RSTATUS_REG_DEFAULT,
    parameter int MULT_OVF_CODE = MULT_OVF_CODE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    mult_issue_ctrl_if.slave   bus
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic        mult_start_q, mult_start_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        timeout_err_q, timeout_err_d;

    logic        cnt_clr;
    logic        cnt_en;
    logic        guard_ok;
    logic        expired;

    mult_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .guard_ok (guard_ok),
        .expired  (expired)
    );

    // next state, operand holding and next-cycle output values; outputs are pulses defaulting to 0
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        rd_d          = rd_q;
        mult_start_d  = 1'b0;
        wb_valid_d    = 1'b0;
        wb_rd_d       = '0;
        wb_data_d     = '0;
        timeout_err_d = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d          = bus.req_a;
                    b_d          = bus.req_b;
                    rd_d         = bus.req_rd;
                    cnt_clr      = 1'b1;
                    mult_start_d = 1'b1;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // a qualified result beats an expiry on the same cycle
                if (bus.mult_ready && guard_ok) begin
                    state_d = ST_DONE;
                    if (bus.mult_ovf) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = 5'(RSTATUS_REG);
                        wb_data_d  = 32'(MULT_OVF_CODE);
                    end else if (rd_q != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = bus.mult_result;
                    end
                end else if (expired) begin
                    state_d       = ST_DONE;
                    timeout_err_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, holding and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            rd_q          <= '0;
            mult_start_q  <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rd_q          <= rd_d;
            mult_start_q  <= mult_start_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // stall is gated by reset so the pipeline is released while the controller is held in reset
    assign bus.stall = ~reset & (((state_q == ST_IDLE) & bus.req_valid) |
                                 (state_q == ST_START) | (state_q == ST_WAIT));

    assign bus.mult_start  = mult_start_q;
    assign bus.mult_a      = a_q;
    assign bus.mult_b      = b_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - self-checking bench for mult_issue_ctrl
module tb_mult_issue_ctrl;

    localparam int TO       = 24;
    localparam int EXP_RSTS = 30;
    localparam int EXP_CODE = 4;

    typedef struct packed {
        int          done_cyc;
        int          stall_cnt;
        int          start_cnt;
        int          start_cyc;
        int          wb_cnt;
        int          pulse_cyc;
        int          to_cnt;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        ops_ok;
    } obs_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mult_issue_ctrl_if bus ();

    mult_issue_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary required summary");
        $fatal(1);
    end

    function automatic logic signed [63:0] full_product(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    function automatic bit product_ovf(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [63:0] lo;
        logic [31:0]        p32;
        p   = full_product(a, b);
        p32 = p[31:0];
        lo  = $signed(p32);
        return p != lo;
    endfunction

    // reference: ready seen at wait index ready_idx (held from then on); -1 means never
    function automatic obs_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input int ready_idx);
        obs_t e;
        int   idx;
        bit   abort;
        logic signed [63:0] p;
        e     = '0;
        p     = full_product(a, b);
        abort = (ready_idx < 0);
        idx   = abort ? TO : ((ready_idx < 2) ? 2 : ready_idx);
        if (idx > TO) begin
            abort = 1'b1;
            idx   = TO;
        end
        e.done_cyc  = 3 + idx;
        e.stall_cnt = 3 + idx;
        e.start_cnt = 1;
        e.start_cyc = 1;
        e.ops_ok    = 1'b1;
        e.pulse_cyc = -1;
        if (abort) begin
            e.to_cnt    = 1;
            e.pulse_cyc = e.done_cyc;
        end else if (product_ovf(a, b)) begin
            e.wb_cnt    = 1;
            e.wb_rd     = 5'(EXP_RSTS);
            e.wb_data   = 32'(EXP_CODE);
            e.pulse_cyc = e.done_cyc;
        end else if (rd != 5'd0) begin
            e.wb_cnt    = 1;
            e.wb_rd     = rd;
            e.wb_data   = p[31:0];
            e.pulse_cyc = e.done_cyc;
        end
        return e;
    endfunction

    // drives one request and plays the multiplier; cycle 0 is the IDLE request cycle
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int ready_idx, input bit stale, output obs_t o);
        int start_at;
        int widx;
        bit rdy;
        logic signed [63:0] p;
        bit ovf;
        p  = full_product(a, b);
        ovf = product_ovf(a, b);
        o = '0;
        o.done_cyc  = -1;
        o.start_cyc = -1;
        o.pulse_cyc = -1;
        o.ops_ok    = 1'b1;
        start_at    = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        for (int c = 0; c < TO + 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.stall) o.stall_cnt++;
            if (bus.mult_start) begin
                o.start_cnt++;
                if (start_at < 0) begin
                    start_at    = c;
                    o.start_cyc = c;
                end
            end
            if (bus.wb_valid) begin
                o.wb_cnt++;
                o.wb_rd     = bus.wb_rd;
                o.wb_data   = bus.wb_data;
                o.pulse_cyc = c;
            end
            if (bus.timeout_err) begin
                o.to_cnt++;
                o.pulse_cyc = c;
            end
            if (c >= 1 && (bus.mult_a !== a || bus.mult_b !== b)) o.ops_ok = 1'b0;
            widx = (start_at >= 0 && c > start_at) ? (c - start_at - 1) : -1;
            rdy  = (ready_idx >= 0) && (widx >= ready_idx);
            bus.mult_ready  = rdy || (stale && (c == start_at || (widx >= 0 && widx < 2)));
            bus.mult_result = rdy ? p[31:0] : ~p[31:0];
            bus.mult_ovf    = rdy && ovf;
            if (c > 0 && !bus.stall) begin
                o.done_cyc    = c;
                bus.req_valid = 1'b0;
                break;
            end
        end
        bus.req_valid  = 1'b0;
        bus.mult_ready = 1'b0;
        bus.mult_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        logic [104:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b1;
        #1;
        outs = {bus.stall, bus.mult_start, bus.mult_a, bus.mult_b, bus.wb_valid,
                bus.wb_rd, bus.wb_data, bus.timeout_err};
        n_checks++;
        if (outs !== 105'd0) $display("FAIL reset_outputs: got %h required 0", outs);
        else n_pass++;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1;
        outs = {bus.stall, bus.mult_start, bus.mult_a, bus.mult_b, bus.wb_valid,
                bus.wb_rd, bus.wb_data, bus.timeout_err};
        n_checks++;
        if (outs !== 105'd0) $display("FAIL post_reset_idle: got %h required 0", outs);
        else n_pass++;
    endtask

    task automatic test_basic();
        obs_t o, e;
        run_op(32'd7, 32'd6, 5'd5, 16, 1'b0, o);
        e = model(32'd7, 32'd6, 5'd5, 16);
        n_checks++;
        if (o !== e) $display("FAIL basic_model: got %p required %p", o, e);
        else n_pass++;
        n_checks++;
        if (o.stall_cnt !== 19) $display("FAIL basic_stall_cycles: got %0d required 19", o.stall_cnt);
        else n_pass++;
        n_checks++;
        if (o.start_cnt !== 1) $display("FAIL basic_start_pulses: got %0d required 1", o.start_cnt);
        else n_pass++;
        n_checks++;
        if (o.wb_rd !== 5'd5 || o.wb_data !== 32'd42 || o.wb_cnt !== 1)
            $display("FAIL basic_writeback: got rd=%0d data=%0d n=%0d required rd=5 data=42 n=1",
                     o.wb_rd, o.wb_data, o.wb_cnt);
        else n_pass++;
    endtask

    task automatic test_overflow();
        obs_t o, e;
        run_op(32'h4000_0000, 32'd4, 5'd9, 5, 1'b0, o);
        e = model(32'h4000_0000, 32'd4, 5'd9, 5);
        n_checks++;
        if (o !== e) $display("FAIL ovf_model: got %p required %p", o, e);
        else n_pass++;
        n_checks++;
        if (o.wb_rd !== 5'd30 || o.wb_data !== 32'd4)
            $display("FAIL ovf_redirect: got rd=%0d data=%0d required rd=30 data=4", o.wb_rd, o.wb_data);
        else n_pass++;
    endtask

    task automatic test_stale_ready();
        obs_t o, e;
        run_op(32'd123, -32'd7, 5'd12, 10, 1'b1, o);
        e = model(32'd123, -32'd7, 5'd12, 10);
        n_checks++;
        if (o !== e) $display("FAIL stale_model: got %p required %p", o, e);
        else n_pass++;
        n_checks++;
        if (o.done_cyc !== 13 || o.wb_data !== 32'hFFFF_FCA3)
            $display("FAIL stale_capture: got done=%0d data=%h required done=13 data=fffffca3",
                     o.done_cyc, o.wb_data);
        else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o, e;
        run_op(32'd5, 32'd5, 5'd3, -1, 1'b0, o);
        e = model(32'd5, 32'd5, 5'd3, -1);
        n_checks++;
        if (o !== e) $display("FAIL timeout_model: got %p required %p", o, e);
        else n_pass++;
        n_checks++;
        if (o.pulse_cyc !== 27 || o.to_cnt !== 1 || o.wb_cnt !== 0 || o.done_cyc !== 27)
            $display("FAIL timeout_pulse: got cyc=%0d n=%0d wb=%0d done=%0d required 27 1 0 27",
                     o.pulse_cyc, o.to_cnt, o.wb_cnt, o.done_cyc);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.stall, bus.mult_start, bus.timeout_err, bus.wb_valid} !== 4'b0)
            $display("FAIL timeout_back_to_idle: got %b required 0000",
                     {bus.stall, bus.mult_start, bus.timeout_err, bus.wb_valid});
        else n_pass++;
        // ready qualifies on the very cycle the counter reaches TIMEOUT
        run_op(32'd11, 32'd3, 5'd4, TO, 1'b0, o);
        e = model(32'd11, 32'd3, 5'd4, TO);
        n_checks++;
        if (o !== e || o.to_cnt !== 0 || o.wb_data !== 32'd33)
            $display("FAIL timeout_tie: got %p required %p", o, e);
        else n_pass++;
    endtask

    task automatic test_r0();
        obs_t o, e;
        run_op(32'd3, 32'd3, 5'd0, 4, 1'b0, o);
        e = model(32'd3, 32'd3, 5'd0, 4);
        n_checks++;
        if (o !== e || o.wb_cnt !== 0) $display("FAIL r0_suppressed: got %p required %p", o, e);
        else n_pass++;
        run_op(32'h8000_0000, 32'h8000_0000, 5'd0, 6, 1'b0, o);
        e = model(32'h8000_0000, 32'h8000_0000, 5'd0, 6);
        n_checks++;
        if (o !== e || o.wb_cnt !== 1 || o.wb_rd !== 5'd30)
            $display("FAIL r0_ovf_written: got %p required %p", o, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        logic [104:0] outs;
        obs_t o, e;
        int start_at;
        int widx;
        start_at = -1;
        widx     = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd200;
        bus.req_rd    = 5'd7;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.mult_start && start_at < 0) start_at = c;
            widx = (start_at >= 0 && c > start_at) ? (c - start_at - 1) : -1;
            if (widx == 5) break;
        end
        n_checks++;
        if (widx !== 5) $display("FAIL reset_reach_wait: got wait index %0d required 5", widx);
        else n_pass++;
        reset = 1'b1;
        #1;
        outs = {bus.stall, bus.mult_start, bus.mult_a, bus.mult_b, bus.wb_valid,
                bus.wb_rd, bus.wb_data, bus.timeout_err};
        n_checks++;
        if (outs !== 105'd0) $display("FAIL reset_mid_wait_outputs: got %h required 0", outs);
        else n_pass++;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        outs = {bus.stall, bus.mult_start, bus.mult_a, bus.mult_b, bus.wb_valid,
                bus.wb_rd, bus.wb_data, bus.timeout_err};
        n_checks++;
        if (outs !== 105'd0) $display("FAIL reset_release_outputs: got %h required 0", outs);
        else n_pass++;
        run_op(-32'd3, 32'd5, 5'd2, 8, 1'b0, o);
        e = model(-32'd3, 32'd5, 5'd2, 8);
        n_checks++;
        if (o !== e || o.wb_data !== 32'hFFFF_FFF1 || !o.ops_ok)
            $display("FAIL reset_then_mul: got %p required %p", o, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2, e1, e2;
        run_op(32'd1000, 32'd1000, 5'd17, 3, 1'b0, o1);
        run_op(32'd9, -32'd9, 5'd18, 2, 1'b1, o2);
        e1 = model(32'd1000, 32'd1000, 5'd17, 3);
        e2 = model(32'd9, -32'd9, 5'd18, 2);
        n_checks++;
        if (o1 !== e1) $display("FAIL b2b_first: got %p required %p", o1, e1);
        else n_pass++;
        n_checks++;
        if (o2 !== e2) $display("FAIL b2b_second: got %p required %p", o2, e2);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          ri;
        bit          st;
        for (int i = 0; i < 24; i++) begin
            a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3000));
            b  = ($urandom_range(0, 1) == 1) ? $urandom : -32'($urandom_range(0, 300));
            rd = 5'($urandom_range(0, 31));
            ri = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO + 3));
            st = 1'($urandom_range(0, 1));
            run_op(a, b, rd, ri, st, o);
            e = model(a, b, rd, ri);
            n_checks++;
            if (o !== e) $display("FAIL random_%0d: got %p required %p", i, o, e);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_rd      = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.mult_result = '0;
        bus.mult_ready  = 1'b0;
        bus.mult_ovf    = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_stale_ready();
        test_timeout();
        test_r0();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
